sb_io_ddr_tx: RTL

//   Parallel-to-DDR transmit serializer for an SB_IO in DDR-output mode: drives D_OUT_0
//   (rising-edge bit), D_OUT_1 (falling-edge bit) and OUTPUT_ENABLE.

---
 rtl/sb_io_ddr_tx_if.sv | 15 +
 rtl/sb_io_ddr_tx.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sb_io_ddr_tx_if.sv
// Word handshake between a data source and the sb_io_ddr_tx serializer.
//   in_data  : word to transmit, bit 0 is sent first
//   in_valid : in_data is valid
//   in_ready : the serializer accepts on an edge where in_valid && in_ready
// master = word source, slave = serializer.
interface sb_io_ddr_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sb_io_ddr_tx.sv
// Parallel-to-DDR transmit serializer for an SB_IO in DDR-output mode.
// Takes WIDTH-bit words over a valid/ready handshake and sends two bits per
// clock, LSB first. Consecutive words stream without a gap. After the last
// word, the output enable stays high for TAIL_CYCLES cycles at the idle level,
// then the pad is released.
//   clk    : sole clock, also the SB_IO OUTPUT_CLK
//   rst    : synchronous, active-high reset
//   in_if  : word handshake (slave side)
//   dout_0 : SB_IO D_OUT_0, rising-edge bit (bit 2k of the word)
//   dout_1 : SB_IO D_OUT_1, falling-edge bit (bit 2k+1 of the word)
//   oen    : SB_IO OUTPUT_ENABLE
//   busy   : a word is being shifted or the tail is running
module sb_io_ddr_tx #(
    parameter int   WIDTH       = 8,
    parameter int   TAIL_CYCLES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    sb_io_ddr_tx_if.slave   in_if,
    output logic            dout_0,
    output logic            dout_1,
    output logic            oen,
    output logic            busy
);
    localparam int BEATS = WIDTH / 2;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TW    = (TAIL_CYCLES > 0) ? $clog2(TAIL_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [TW-1:0] TAIL_END  = TW'(TAIL_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_TAIL
    } state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [WIDTH-1:0] sh_q, sh_n;
    logic [TW-1:0]    tail_q, tail_n;
    logic             d0_q, d0_n;
    logic             d1_q, d1_n;
    logic             oen_q, oen_n;
    logic             ready;
    logic             accept;

    // A new word can be taken whenever the shifter is free or on its last beat.
    assign ready        = !rst && (state_q != ST_SHIFT || cnt_q == LAST_BEAT);
    assign in_if.in_ready = ready;
    assign accept       = in_if.in_valid && ready;
    assign busy         = !rst && (state_q != ST_IDLE);

    assign dout_0 = d0_q;
    assign dout_1 = d1_q;
    assign oen    = oen_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        sh_n    = sh_q;
        tail_n  = tail_q;
        d0_n    = d0_q;
        d1_n    = d1_q;
        oen_n   = oen_q;

        if (accept) begin
            // Loading from any state; on a last beat this chains words with no gap.
            d0_n    = in_if.in_data[0];
            d1_n    = in_if.in_data[1];
            sh_n    = in_if.in_data >> 2;
            cnt_n   = '0;
            oen_n   = 1'b1;
            state_n = ST_SHIFT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    d0_n  = IDLE_LEVEL;
                    d1_n  = IDLE_LEVEL;
                    oen_n = 1'b0;
                end
                ST_SHIFT: begin
                    if (cnt_q != LAST_BEAT) begin
                        d0_n  = sh_q[0];
                        d1_n  = sh_q[1];
                        sh_n  = sh_q >> 2;
                        cnt_n = cnt_q + 1'b1;
                    end else begin
                        d0_n = IDLE_LEVEL;
                        d1_n = IDLE_LEVEL;
                        if (TAIL_CYCLES > 0) begin
                            tail_n  = TW'(1);
                            state_n = ST_TAIL;
                        end else begin
                            oen_n   = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end
                end
                ST_TAIL: begin
                    d0_n = IDLE_LEVEL;
                    d1_n = IDLE_LEVEL;
                    if (tail_q == TAIL_END) begin
                        oen_n   = 1'b0;
                        state_n = ST_IDLE;
                    end else begin
                        tail_n = tail_q + 1'b1;
                    end
                end
                default: begin
                    d0_n    = IDLE_LEVEL;
                    d1_n    = IDLE_LEVEL;
                    oen_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            tail_q  <= '0;
            d0_q    <= IDLE_LEVEL;
            d1_q    <= IDLE_LEVEL;
            oen_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            sh_q    <= sh_n;
            tail_q  <= tail_n;
            d0_q    <= d0_n;
            d1_q    <= d1_n;
            oen_q   <= oen_n;
        end
    end
endmodule
